// File: rtl/s27_lock_pkg.sv
// Shared types and constants for the s27 unlock sequencer and its corruption LFSR.
package s27_lock_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        KEY      = 2'd1,
        UNLOCKED = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    localparam int          CORE_IN_W       = 4;
    localparam logic [15:0] DEFAULT_KEY_SEQ = 16'hA5C3;
    localparam logic [15:0] LFSR_SEED       = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask for a right-shifting register.
    localparam logic [15:0] LFSR_TAPS       = 16'h002D;

endpackage

// File: rtl/s27_key_seq_ctrl_if.sv
// Key word handshake between host (master) and unlock sequencer (slave).
interface s27_key_seq_ctrl_if #(
    parameter int KEY_W = 4
);
    logic [KEY_W-1:0] key_in;
    logic             key_valid;
    logic             key_ready;

    modport master (output key_in, output key_valid, input key_ready);
    modport slave  (input key_in, input key_valid, output key_ready);
endinterface

// File: rtl/s27_lock_lfsr.sv
// 16-bit Fibonacci LFSR, advances one step per enabled cycle, holds otherwise.
// Latency: output is the registered state; no backpressure.
module s27_lock_lfsr
    import s27_lock_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

endmodule

// File: rtl/s27_key_seq_ctrl.sv
// Unlock sequencer for the s27 core: one reset-hold cycle, then KEY_LEN key words; status registered, data paths combinational.
// Host is backpressured only outside KEY (key_ready=0). TRILOCK_CORRUPT_EN adds LFSR corruption of G17 when locked.
module s27_key_seq_ctrl
    import s27_lock_pkg::*;
#(
    parameter int KEY_W   = 4,
    parameter int KEY_LEN = 4,
    parameter     KEY_SEQ = DEFAULT_KEY_SEQ
) (
    input  logic                 clk,
    input  logic                 reset,
    s27_key_seq_ctrl_if.slave    key,
    input  logic [CORE_IN_W-1:0] func_in,
    output logic [CORE_IN_W-1:0] core_in,
    output logic                 core_rst,
    input  logic                 core_g17,
    output logic                 g17_out,
    output logic                 unlocked,
    output logic                 locked_err,
    output logic                 busy
);

    localparam int                      IDX_W    = $clog2(KEY_LEN + 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(KEY_LEN - 1);
    localparam logic [KEY_W*KEY_LEN-1:0] SEQ     = KEY_SEQ;

    if ($bits(KEY_SEQ) != KEY_W * KEY_LEN) begin : g_bad_seq_width
        $error("KEY_SEQ width must equal KEY_W*KEY_LEN");
    end
    if (KEY_W != CORE_IN_W) begin : g_bad_key_width
        $error("KEY_W must equal the core input width");
    end
    if (KEY_LEN < 1 || KEY_LEN > 16) begin : g_bad_key_len
        $error("KEY_LEN must be in 1..16");
    end

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             mism;
    logic             ready_q;
    logic [KEY_W-1:0] exp_word;
    logic             accept;
    logic             mism_next;
    logic             corrupt;

    assign key.key_ready = ready_q;
    assign accept        = key.key_valid && ready_q;
    assign exp_word      = SEQ[int'(idx) * KEY_W +: KEY_W];
    assign mism_next     = mism | (key.key_in != exp_word);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RST_HOLD;
            idx        <= '0;
            mism       <= 1'b0;
            ready_q    <= 1'b0;
            unlocked   <= 1'b0;
            locked_err <= 1'b0;
            core_rst   <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                RST_HOLD: begin
                    state    <= KEY;
                    core_rst <= 1'b0;
                    ready_q  <= 1'b1;
                end
                KEY: begin
                    if (accept) begin
                        idx  <= idx + 1'b1;
                        mism <= mism_next;
                        // Verdict uses the mismatch including the word landing now.
                        if (idx == LAST_IDX) begin
                            ready_q <= 1'b0;
                            busy    <= 1'b0;
                            if (mism_next) begin
                                state      <= LOCKED;
                                locked_err <= 1'b1;
                            end else begin
                                state    <= UNLOCKED;
                                unlocked <= 1'b1;
                            end
                        end
                    end
                end
                UNLOCKED, LOCKED: begin
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

    // Core keeps the state it built during KEY; it is never reset on the handover.
    always_comb begin
        core_in = '0;
        case (state)
            KEY:              if (key.key_valid) core_in = key.key_in;
            UNLOCKED, LOCKED: core_in = func_in;
            default:          core_in = '0;
        endcase
    end

`ifdef TRILOCK_CORRUPT_EN
    logic [15:0] lfsr;

    s27_lock_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state == LOCKED),
        .lfsr  (lfsr)
    );

    assign corrupt = core_g17 ^ lfsr[0];
`else
    assign corrupt = 1'b0;
`endif

    always_comb begin
        g17_out = 1'b0;
        case (state)
            UNLOCKED: g17_out = core_g17;
            LOCKED:   g17_out = corrupt;
            default:  g17_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_s27_key_seq_ctrl.sv
// Scoreboard bench for s27_key_seq_ctrl: random key sequences versus a sequence-equality model.
module tb_s27_key_seq_ctrl;

    localparam logic [15:0] DEF_SEQ = 16'hA5C3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_b = 1'b0;
    logic [3:0] func_in = '0, func_b = '0;
    logic       core_g17 = 1'b0, core_g17_b = 1'b0;
    logic [3:0] core_in, core_in_b;
    logic       core_rst, core_rst_b, g17_out, g17_out_b;
    logic       unlocked, unlocked_b, locked_err, locked_err_b, busy, busy_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_core[$];
    bit         exp_out[$];
    logic       prev_busy = 1'b1;

    s27_key_seq_ctrl_if #(.KEY_W(4)) ifc ();
    s27_key_seq_ctrl_if #(.KEY_W(4)) ifc_b ();

    s27_key_seq_ctrl dut (
        .clk(clk), .reset(rst), .key(ifc), .func_in(func_in), .core_in(core_in),
        .core_rst(core_rst), .core_g17(core_g17), .g17_out(g17_out),
        .unlocked(unlocked), .locked_err(locked_err), .busy(busy)
    );

    s27_key_seq_ctrl #(.KEY_W(4), .KEY_LEN(2), .KEY_SEQ(8'h5F)) dut_b (
        .clk(clk), .reset(rst_b), .key(ifc_b), .func_in(func_b), .core_in(core_in_b),
        .core_rst(core_rst_b), .core_g17(core_g17_b), .g17_out(g17_out_b),
        .unlocked(unlocked_b), .locked_err(locked_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the sequence unlocks iff every word equals its slice of the key.
    function automatic bit model_ok(input logic [63:0] seq, input int len, input logic [3:0] ws[$]);
        if (ws.size() != len) return 1'b0;
        for (int i = 0; i < len; i++)
            if (64'(ws[i]) != ((seq >> (4 * i)) & 64'hF)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] good_word(input int i);
        return 4'((DEF_SEQ >> (4 * i)) & 16'hF);
    endfunction

    // Monitor: checks every presented key word and every verdict against queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.key_ready) begin
                if (ifc.key_valid) begin
                    if (exp_core.size() == 0) chk("core_in_unexpected_word", 1, 0);
                    else chk("core_in_key", 32'(core_in), 32'(exp_core.pop_front()));
                end else begin
                    chk("core_in_idle", 32'(core_in), 0);
                end
            end
            if (prev_busy && !busy) begin
                if (exp_out.size() == 0) begin
                    chk("verdict_unexpected", 1, 0);
                end else begin
                    bit e;
                    e = exp_out.pop_front();
                    chk("verdict_unlocked", 32'(unlocked), 32'(e));
                    chk("verdict_locked_err", 32'(locked_err), 32'(!e));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_key_ready"}, 32'(ifc.key_ready), 0);
        chk({tag, "_unlocked"}, 32'(unlocked), 0);
        chk({tag, "_locked_err"}, 32'(locked_err), 0);
        chk({tag, "_core_in"}, 32'(core_in), 0);
        chk({tag, "_g17_out"}, 32'(g17_out), 0);
    endtask

    task automatic assert_reset(input string tag);
        @(posedge clk); #1;
        ifc.key_valid = 1'b0;
        rst = 1'b0;
        #2;
        reset_vals(tag);
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("hold_core_rst", 32'(core_rst), 1);
        chk("hold_key_ready", 32'(ifc.key_ready), 0);
        chk("hold_core_in", 32'(core_in), 0);
        @(posedge clk); #1;
        chk("key_core_rst", 32'(core_rst), 0);
    endtask

    task automatic send_seq(input logic [3:0] ws[$], input int gaps[$], input bit complete);
        for (int i = 0; i < ws.size(); i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                chk("key_ready_gap", 32'(ifc.key_ready), 1);
                ifc.key_valid = 1'b0;
                ifc.key_in = 4'($urandom);
                @(posedge clk); #1;
            end
            chk("key_ready_word", 32'(ifc.key_ready), 1);
            ifc.key_valid = 1'b1;
            ifc.key_in = ws[i];
            exp_core.push_back(ws[i]);
            @(posedge clk); #1;
        end
        ifc.key_valid = 1'b0;
        if (complete) exp_out.push_back(model_ok(64'(DEF_SEQ), 4, ws));
    endtask

    task automatic finish_check(input bit exp_unl);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 8);
        chk("done_within_bound", 32'(busy), 0);
        chk("final_unlocked", 32'(unlocked), 32'(exp_unl));
        chk("final_locked_err", 32'(locked_err), 32'(!exp_unl));
        func_in = 4'($urandom);
        core_g17 = 1'($urandom);
        #1;
        chk("func_passthrough", 32'(core_in), 32'(func_in));
        if (exp_unl) begin
            chk("g17_unlocked", 32'(g17_out), 32'(core_g17));
        end else begin
`ifdef TRILOCK_CORRUPT_EN
            int diffs;
            diffs = 0;
            repeat (16) begin
                @(negedge clk);
                if (g17_out != core_g17) diffs++;
            end
            chk("g17_corrupted", 32'(diffs != 0), 1);
`else
            chk("g17_locked", 32'(g17_out), 0);
`endif
        end
    endtask

    task automatic run_b(input logic [3:0] w0, input logic [3:0] w1);
        logic [3:0] q[$];
        bit e;
        q.push_back(w0);
        q.push_back(w1);
        e = model_ok(64'h5F, 2, q);
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        ifc_b.key_valid = 1'b1;
        ifc_b.key_in = w0;
        @(posedge clk); #1;
        ifc_b.key_in = w1;
        @(posedge clk); #1;
        ifc_b.key_valid = 1'b0;
        @(negedge clk);
        chk("var_unlocked", 32'(unlocked_b), 32'(e));
        chk("var_locked_err", 32'(locked_err_b), 32'(!e));
        chk("var_busy", 32'(busy_b), 0);
    endtask

    logic [3:0] ws[$];
    int         gp[$];

    initial begin
        ifc.key_valid = 1'b0;
        ifc.key_in = '0;
        ifc_b.key_valid = 1'b0;
        ifc_b.key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals("por");

        // Correct key back to back: unlocked in cycle 6 after release.
        release_reset();
        ws = '{4'h3, 4'hC, 4'h5, 4'hA};
        gp = '{0, 0, 0, 0};
        send_seq(ws, gp, 1'b1);
        @(negedge clk);
        chk("latency_unlocked", 32'(unlocked), 1);
        chk("latency_locked_err", 32'(locked_err), 0);
        func_in = 4'h9;
        core_g17 = 1'b1;
        #1;
        chk("func_9", 32'(core_in), 32'h9);
        chk("g17_track_hi", 32'(g17_out), 1);
        core_g17 = 1'b0;
        #1;
        chk("g17_track_lo", 32'(g17_out), 0);
        finish_check(1'b1);

        // Reset in UNLOCKED: three correct words must not unlock again.
        assert_reset("rst_unlocked");
        release_reset();
        ws = '{4'h3, 4'hC, 4'h5};
        gp = '{0, 0, 0};
        send_seq(ws, gp, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("partial_busy", 32'(busy), 1);
            chk("partial_unlocked", 32'(unlocked), 0);
        end

        // Wrong third word.
        assert_reset("rst_wrong");
        release_reset();
        ws = '{4'h3, 4'hC, 4'h4, 4'hA};
        gp = '{0, 0, 0, 0};
        send_seq(ws, gp, 1'b1);
        finish_check(1'b0);

        // Idle gaps between words.
        assert_reset("rst_gaps");
        release_reset();
        ws = '{4'h3, 4'hC, 4'h5, 4'hA};
        gp = '{0, 5, 1, 0};
        send_seq(ws, gp, 1'b1);
        finish_check(1'b1);

        // Reset after the second word, then a fresh full sequence.
        assert_reset("rst_pre_mid");
        release_reset();
        ws = '{4'h3, 4'hC};
        gp = '{0, 0};
        send_seq(ws, gp, 1'b0);
        assert_reset("rst_mid");
        release_reset();
        ws = '{4'h3, 4'hC, 4'h5, 4'hA};
        gp = '{0, 0, 0, 0};
        send_seq(ws, gp, 1'b1);
        finish_check(1'b1);

        for (int t = 0; t < 24; t++) begin
            int k;
            bit allgood;
            allgood = ($urandom_range(0, 2) == 0);
            ws = {};
            gp = {};
            for (int i = 0; i < 4; i++) begin
                ws.push_back((allgood || $urandom_range(0, 1) == 1) ? good_word(i) : 4'($urandom));
                gp.push_back(int'($urandom_range(0, 2)));
            end
            assert_reset("rst_rand");
            release_reset();
            if ($urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(1, 3));
                while (ws.size() > k) begin
                    void'(ws.pop_back());
                    void'(gp.pop_back());
                end
                send_seq(ws, gp, 1'b0);
            end else begin
                send_seq(ws, gp, 1'b1);
                finish_check(model_ok(64'(DEF_SEQ), 4, ws));
            end
        end

        run_b(4'hF, 4'h5);
        run_b(4'h5, 4'hF);

        @(negedge clk);
        chk("core_queue_drained", 32'(exp_core.size()), 0);
        chk("verdict_queue_drained", 32'(exp_out.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s27_key_seq_ctrl.md
Name: s27_key_seq_ctrl

Overview:
- Unlock sequencer placed in front of the locked s27 core.
- After reset it holds the core in reset for one cycle. It then accepts a KEY_LEN-word key sequence through a valid/ready handshake and drives each accepted word onto the core's four primary inputs.
- Once the sequence completes, it either hands the core inputs to the functional inputs (unlocked) or enters a permanent locked state until the next reset.
- It also gates the core's G17 output.

Parameters:
- KEY_W, 4, key word width; must equal the core input width (G0..G3).
- KEY_LEN, 4, number of key words in the sequence; range 1..16.
- KEY_SEQ, 16'hA5C3, correct key sequence. Word i = KEY_SEQ[i*KEY_W +: KEY_W].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_in  in  KEY_W  key word from host
- key_valid  in  1  key_in is valid
- key_ready  out  1  controller accepts a key word this cycle
- func_in  in  4  functional inputs {G3,G2,G1,G0}
- core_in  out  4  drives core {G3,G2,G1,G0}
- core_rst  out  1  active-high synchronous reset to the core flops
- core_g17  in  1  core output G17
- g17_out  out  1  gated G17 to the system
- unlocked  out  1  unlock succeeded
- locked_err  out  1  wrong key was applied
- busy  out  1  controller is in RST_HOLD or KEY

Behaviour:
- Clocking and reset: all flops are on posedge clk. Asserting reset (low) is asynchronous at any time, including mid-sequence, and forces:
  - state=RST_HOLD, idx=0, mism=0
  - key_ready=0, unlocked=0, locked_err=0
  - core_rst=1, busy=1, core_in=0, g17_out=0
- State machine:
  - RST_HOLD: core_rst=1, core_in=0. Next cycle goes to KEY unconditionally.
  - KEY:
    - core_rst=0, key_ready=1.
    - core_in = key_in when key_valid=1, else 0.
    - A word is accepted when key_valid && key_ready.
    - On accept: mism <= mism | (key_in != KEY_SEQ word idx), and idx <= idx+1.
    - On the accept where idx==KEY_LEN-1: go to UNLOCKED if the final mism (including this word) is 0, else go to LOCKED. key_ready drops in the following cycle.
    - Cycles with key_valid=0 do not advance idx. There is no timeout.
  - UNLOCKED:
    - core_in = func_in (combinational pass-through), g17_out = core_g17.
    - unlocked=1, busy=0, key_ready=0. Terminal state until reset.
  - LOCKED:
    - core_in = func_in, locked_err=1, busy=0, key_ready=0. Terminal state until reset.
    - g17_out is defined under Optional Feature.
- Timing and latency:
  - g17_out is 0 in RST_HOLD and KEY.
  - unlocked and locked_err are registered and assert in the first cycle of their state.
  - Minimum reset-release to unlocked latency is 1+KEY_LEN cycles.
- Width rules:
  - idx is $clog2(KEY_LEN+1) bits.
  - Comparison is a full KEY_W-bit equality.
  - KEY_SEQ is sized KEY_W*KEY_LEN bits; an elaboration check fails on mismatch.
- The core state built up during KEY is intentionally preserved into UNLOCKED; the core is not reset on the transition.
- A simultaneous reset assertion and final key accept: reset wins.

Optional Feature:
- Macro: TRILOCK_CORRUPT_EN
- Defined:
  - A 16-bit Fibonacci LFSR runs in LOCKED, with taps 16,14,13,11 and seed 16'hACE1 loaded on reset.
  - g17_out = core_g17 ^ lfsr[0].
  - The LFSR holds its value outside LOCKED.
- Undefined: the LFSR is absent, and g17_out=0 in LOCKED.

Decomposition:
- Package s27_lock_pkg:
  - state enum {RST_HOLD, KEY, UNLOCKED, LOCKED}, 2 bits
  - CORE_IN_W=4
  - default KEY_SEQ constant
  - LFSR seed and tap constants
- One sub-module, s27_lock_lfsr: a 16-bit LFSR with enable, instantiated only under TRILOCK_CORRUPT_EN.

Test Plan:
- Correct key: release reset, then apply 3, C, 5, A on consecutive cycles with key_valid=1.
  - unlocked=1 on cycle 6 after release, locked_err=0.
  - core_in shows 3, C, 5, A in cycles 2-5.
  - Afterwards, func_in=4'h9 gives core_in=4'h9, and g17_out tracks core_g17.
- Wrong key: apply 3, C, 4, A.
  - locked_err=1, unlocked=0.
  - g17_out=0 with the macro off; with the macro on it differs from core_g17 on some cycle within 16 cycles.
- Gaps: apply 3, idle 5 cycles, C, idle, 5, A.
  - idx advances only on accepts, and unlock succeeds.
  - key_ready stays 1 throughout KEY.
- Reset mid-sequence: assert reset after the 2nd word.
  - All outputs return to reset values, with core_rst=1 and busy=1.
  - A fresh correct 4-word sequence then unlocks.
- Reset in UNLOCKED: assert reset.
  - unlocked=0, and the full sequence is required again.
- Parameter variant KEY_LEN=2, KEY_SEQ=8'h5F: F then 5 gives unlocked, and 5 then F gives locked_err.
